// File: rtl/multicycle_ctrl_pkg.sv
// Shared types and constants for the multi-cycle LEGv8 main control unit:
// FSM states, instruction classes, opcode patterns and datapath select codes.
package arki_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        EXEC_MEM,
        EXEC_R,
        EXEC_CBZ,
        EXEC_B,
        MEM,
        WB,
        FAULT
    } state_t;

    typedef enum logic [2:0] {
        LD,
        ST,
        CBZ,
        B,
        RTYPE,
        ILLEGAL
    } op_class_t;

    // '?' bits are register/offset fields that do not affect the class
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [10:0] OP_CBZ  = 11'b10110100???;
    localparam logic [10:0] OP_B    = 11'b000101?????;
    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;

    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_PASS_B = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT  = 2'b10;

    localparam logic [1:0] PCSRC_PC4    = 2'b00;
    localparam logic [1:0] PCSRC_BRANCH = 2'b01;

    // STUR stores Rt and CBZ tests Rt, so both read Rt on the second port
    function automatic logic uses_rt(op_class_t c);
        return (c == ST) || (c == CBZ);
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Memory handshake between the control unit (master) and the memory/datapath
// side (slave): request, address select, direction and completion.
interface multicycle_ctrl_if;

    logic mem_req;
    logic mem_ready;
    logic IorD;
    logic MemRead;
    logic MemWrite;

    modport master (
        output mem_req,
        output IorD,
        output MemRead,
        output MemWrite,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  IorD,
        input  MemRead,
        input  MemWrite,
        output mem_ready
    );

endinterface

// File: rtl/multicycle_ctrl_op_class_dec.sv
// Combinational opcode classifier: maps the 11-bit LEGv8 opcode field to the
// instruction class that selects the execute path.
module op_class_dec
    import arki_ctrl_pkg::*;
#(
    parameter int OPCODE_W = 11
) (
    input  logic [OPCODE_W-1:0] op,
    output op_class_t           op_class
);

    always_comb begin
        op_class = ILLEGAL;
        casez (op)
            OP_LDUR: op_class = LD;
            OP_STUR: op_class = ST;
            OP_CBZ:  op_class = CBZ;
            OP_B:    op_class = B;
            OP_ADD,
            OP_SUB,
            OP_AND,
            OP_ORR:  op_class = RTYPE;
            default: op_class = ILLEGAL;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle LEGv8 main control FSM: sequences FETCH/DECODE/EXEC/MEM/WB,
// handles memory wait states with a timeout, flags faults and counts retirements.
module multicycle_ctrl
    import arki_ctrl_pkg::*;
#(
    parameter int OPCODE_W    = 11,
    parameter int ALUOP_W     = 2,
    parameter int MEM_TIMEOUT = 16,
    parameter int RETIRE_W    = 32
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [OPCODE_W-1:0] op,
    input  logic                alu_zero,
    multicycle_ctrl_if.master   mem,
    output logic                IRWrite,
    output logic                PCWrite,
    output logic [1:0]          PCSrc,
    output logic                Reg2Loc,
    output logic                ALUSrc,
    output logic [ALUOP_W-1:0]  ALUOp,
    output logic                MemtoReg,
    output logic                RegWrite,
    output logic                retire,
    output logic [RETIRE_W-1:0] retire_cnt,
    output logic                illegal,
    output logic                timeout_err
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    state_t              state_q, state_d;
    op_class_t           class_q, class_d;
    op_class_t           dec_class;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [RETIRE_W-1:0] retire_cnt_q, retire_cnt_d;
    logic                illegal_q, illegal_d;
    logic                timeout_q, timeout_d;
    logic                active_q, active_d;

    logic       mem_req_c;
    logic       iord_c;
    logic       mem_read_c;
    logic       mem_write_c;
    logic       ir_write_c;
    logic       pc_write_c;
    logic [1:0] pc_src_c;
    logic       reg2loc_c;
    logic       alu_src_c;
    logic [1:0] alu_op_c;
    logic       mem_to_reg_c;
    logic       reg_write_c;
    logic       retire_c;

    op_class_dec #(
        .OPCODE_W (OPCODE_W)
    ) u_dec (
        .op       (op),
        .op_class (dec_class)
    );

    // active_q keeps every output low during and for one cycle after reset,
    // so the reset state FETCH does not raise mem_req until reset is released.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= FETCH;
            class_q      <= ILLEGAL;
            wait_q       <= '0;
            retire_cnt_q <= '0;
            illegal_q    <= 1'b0;
            timeout_q    <= 1'b0;
            active_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            class_q      <= class_d;
            wait_q       <= wait_d;
            retire_cnt_q <= retire_cnt_d;
            illegal_q    <= illegal_d;
            timeout_q    <= timeout_d;
            active_q     <= active_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        class_d      = class_q;
        wait_d       = '0;
        illegal_d    = illegal_q;
        timeout_d    = timeout_q;
        active_d     = 1'b1;
        mem_req_c    = 1'b0;
        iord_c       = 1'b0;
        mem_read_c   = 1'b0;
        mem_write_c  = 1'b0;
        ir_write_c   = 1'b0;
        pc_write_c   = 1'b0;
        pc_src_c     = PCSRC_PC4;
        reg2loc_c    = 1'b0;
        alu_src_c    = 1'b0;
        alu_op_c     = ALUOP_ADD;
        mem_to_reg_c = 1'b0;
        reg_write_c  = 1'b0;
        retire_c     = 1'b0;

        if (active_q) begin
            unique case (state_q)
                FETCH: begin
                    mem_req_c  = 1'b1;
                    mem_read_c = 1'b1;
                    if (mem.mem_ready) begin
                        ir_write_c = 1'b1;
                        pc_write_c = 1'b1;
                        state_d    = DECODE;
                    end else if (wait_q == WAIT_LAST) begin
                        timeout_d = 1'b1;
                        state_d   = FAULT;
                    end else begin
                        wait_d = wait_q + WAIT_W'(1);
                    end
                end

                DECODE: begin
                    reg2loc_c = uses_rt(dec_class);
                    class_d   = dec_class;
                    unique case (dec_class)
                        LD, ST:  state_d = EXEC_MEM;
                        RTYPE:   state_d = EXEC_R;
                        CBZ:     state_d = EXEC_CBZ;
                        B:       state_d = EXEC_B;
                        default: begin
                            illegal_d = 1'b1;
                            state_d   = FAULT;
                        end
                    endcase
                end

                EXEC_MEM: begin
                    reg2loc_c = uses_rt(class_q);
                    alu_src_c = 1'b1;
                    state_d   = MEM;
                end

                EXEC_R: begin
                    alu_op_c = ALUOP_FUNCT;
                    state_d  = WB;
                end

                EXEC_CBZ: begin
                    reg2loc_c  = 1'b1;
                    alu_op_c   = ALUOP_PASS_B;
                    pc_src_c   = PCSRC_BRANCH;
                    pc_write_c = alu_zero;
                    retire_c   = 1'b1;
                    state_d    = FETCH;
                end

                EXEC_B: begin
                    pc_src_c   = PCSRC_BRANCH;
                    pc_write_c = 1'b1;
                    retire_c   = 1'b1;
                    state_d    = FETCH;
                end

                // Address and direction stay stable for the whole wait
                MEM: begin
                    mem_req_c   = 1'b1;
                    iord_c      = 1'b1;
                    reg2loc_c   = uses_rt(class_q);
                    mem_read_c  = (class_q == LD);
                    mem_write_c = (class_q == ST);
                    if (mem.mem_ready) begin
                        if (class_q == LD) begin
                            state_d = WB;
                        end else begin
                            retire_c = 1'b1;
                            state_d  = FETCH;
                        end
                    end else if (wait_q == WAIT_LAST) begin
                        timeout_d = 1'b1;
                        state_d   = FAULT;
                    end else begin
                        wait_d = wait_q + WAIT_W'(1);
                    end
                end

                WB: begin
                    reg_write_c  = 1'b1;
                    mem_to_reg_c = (class_q == LD);
                    retire_c     = 1'b1;
                    state_d      = FETCH;
                end

                FAULT: begin
                    state_d = FAULT;
                end

                default: begin
                    state_d = FAULT;
                end
            endcase
        end

        retire_cnt_d = retire_c ? retire_cnt_q + RETIRE_W'(1) : retire_cnt_q;
    end

    assign mem.mem_req  = mem_req_c;
    assign mem.IorD     = iord_c;
    assign mem.MemRead  = mem_read_c;
    assign mem.MemWrite = mem_write_c;

    assign IRWrite     = ir_write_c;
    assign PCWrite     = pc_write_c;
    assign PCSrc       = pc_src_c;
    assign Reg2Loc     = reg2loc_c;
    assign ALUSrc      = alu_src_c;
    assign ALUOp       = ALUOP_W'(alu_op_c);
    assign MemtoReg    = mem_to_reg_c;
    assign RegWrite    = reg_write_c;
    assign retire      = retire_c;
    assign retire_cnt  = retire_cnt_q;
    assign illegal     = illegal_q;
    assign timeout_err = timeout_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: each instruction is expanded into a
// per-cycle plan of expected control outputs, then played against the DUT.
module tb_multicycle_ctrl;

    localparam int TIMEOUT = 4;
    localparam int RW      = 2;

    localparam int K_LD  = 0;
    localparam int K_ST  = 1;
    localparam int K_CBZ = 2;
    localparam int K_B   = 3;
    localparam int K_R   = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [10:0]   op = '0;
    logic          alu_zero = 1'b0;
    logic          IRWrite, PCWrite, Reg2Loc, ALUSrc, MemtoReg, RegWrite;
    logic [1:0]    PCSrc, ALUOp;
    logic          retire, illegal, timeout_err;
    logic [RW-1:0] retire_cnt;

    multicycle_ctrl_if mem_if();

    always #5 clk = ~clk;

    multicycle_ctrl #(
        .OPCODE_W    (11),
        .ALUOP_W     (2),
        .MEM_TIMEOUT (TIMEOUT),
        .RETIRE_W    (RW)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .op          (op),
        .alu_zero    (alu_zero),
        .mem         (mem_if),
        .IRWrite     (IRWrite),
        .PCWrite     (PCWrite),
        .PCSrc       (PCSrc),
        .Reg2Loc     (Reg2Loc),
        .ALUSrc      (ALUSrc),
        .ALUOp       (ALUOp),
        .MemtoReg    (MemtoReg),
        .RegWrite    (RegWrite),
        .retire      (retire),
        .retire_cnt  (retire_cnt),
        .illegal     (illegal),
        .timeout_err (timeout_err)
    );

    typedef struct packed {
        logic       mem_req;
        logic       iord;
        logic       ir_write;
        logic       pc_write;
        logic [1:0] pc_src;
        logic       reg2loc;
        logic       alu_src;
        logic [1:0] alu_op;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_write;
        logic       retire;
    } ctl_t;

    typedef struct {
        ctl_t  exp;
        logic  rdy;
        logic  az;
        logic  ill;
        logic  to;
        string tag;
    } step_t;

    int    compared = 0;
    int    mismatched = 0;
    int    retired = 0;
    logic  exp_ill = 1'b0;
    logic  exp_to = 1'b0;
    step_t plan[$];

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic rdy, input logic az);
        mem_if.mem_ready = rdy;
        alu_zero = az;
    endtask

    function automatic ctl_t observed();
        ctl_t o;
        o.mem_req    = mem_if.mem_req;
        o.iord       = mem_if.IorD;
        o.ir_write   = IRWrite;
        o.pc_write   = PCWrite;
        o.pc_src     = PCSrc;
        o.reg2loc    = Reg2Loc;
        o.alu_src    = ALUSrc;
        o.alu_op     = ALUOp;
        o.mem_read   = mem_if.MemRead;
        o.mem_write  = mem_if.MemWrite;
        o.mem_to_reg = MemtoReg;
        o.reg_write  = RegWrite;
        o.retire     = retire;
        return o;
    endfunction

    task automatic pushStep(input ctl_t c, input logic rdy, input logic az, input string tag);
        step_t s;
        s.exp = c;
        s.rdy = rdy;
        s.az  = az;
        s.ill = exp_ill;
        s.to  = exp_to;
        s.tag = tag;
        plan.push_back(s);
    endtask

    function automatic ctl_t fetchCtl(input logic rdy);
        ctl_t c = '0;
        c.mem_req  = 1'b1;
        c.mem_read = 1'b1;
        c.ir_write = rdy;
        c.pc_write = rdy;
        return c;
    endfunction

    function automatic ctl_t memCtl(input int k, input logic rdy);
        ctl_t c = '0;
        c.mem_req   = 1'b1;
        c.iord      = 1'b1;
        c.reg2loc   = (k == K_ST);
        c.mem_read  = (k == K_LD);
        c.mem_write = (k == K_ST);
        c.retire    = rdy && (k == K_ST);
        return c;
    endfunction

    function automatic logic [10:0] pickOp(input int k);
        logic [10:0] rops [4];
        rops[0] = 11'b10001011000;
        rops[1] = 11'b11001011000;
        rops[2] = 11'b10001010000;
        rops[3] = 11'b10101010000;
        case (k)
            K_LD:    return 11'b11111000010;
            K_ST:    return 11'b11111000000;
            K_CBZ:   return {8'b10110100, 3'($urandom)};
            K_B:     return {6'b000101, 5'($urandom)};
            default: return rops[$urandom_range(0, 3)];
        endcase
    endfunction

    task automatic planFetch(input int fw);
        for (int i = 0; i < fw; i++) pushStep(fetchCtl(1'b0), 1'b0, 1'($urandom), "fetch_wait");
        pushStep(fetchCtl(1'b1), 1'b1, 1'($urandom), "fetch_ready");
    endtask

    task automatic planDecode(input int k);
        ctl_t c = '0;
        c.reg2loc = (k == K_ST) || (k == K_CBZ);
        pushStep(c, 1'($urandom), 1'($urandom), "decode");
    endtask

    task automatic planFault(input int n);
        for (int i = 0; i < n; i++) pushStep('0, 1'($urandom), 1'($urandom), "fault");
    endtask

    // Expected cycle-by-cycle behaviour of one instruction given its latencies
    task automatic planInstr(input int k, input int fw, input int mw, input logic az);
        ctl_t c;
        planFetch(fw);
        planDecode(k);
        c = '0;
        case (k)
            K_LD, K_ST: begin
                c.alu_src = 1'b1;
                c.reg2loc = (k == K_ST);
                pushStep(c, 1'($urandom), 1'($urandom), "exec_mem");
                for (int i = 0; i < mw; i++) pushStep(memCtl(k, 1'b0), 1'b0, 1'($urandom), "mem_wait");
                pushStep(memCtl(k, 1'b1), 1'b1, 1'($urandom), "mem_ready");
                if (k == K_LD) begin
                    c = '0;
                    c.reg_write  = 1'b1;
                    c.mem_to_reg = 1'b1;
                    c.retire     = 1'b1;
                    pushStep(c, 1'($urandom), 1'($urandom), "wb_ld");
                end
            end
            K_R: begin
                c.alu_op = 2'b10;
                pushStep(c, 1'($urandom), 1'($urandom), "exec_r");
                c = '0;
                c.reg_write = 1'b1;
                c.retire    = 1'b1;
                pushStep(c, 1'($urandom), 1'($urandom), "wb_r");
            end
            K_CBZ: begin
                c.alu_op   = 2'b01;
                c.pc_src   = 2'b01;
                c.reg2loc  = 1'b1;
                c.pc_write = az;
                c.retire   = 1'b1;
                pushStep(c, 1'($urandom), az, "exec_cbz");
            end
            default: begin
                c.pc_src   = 2'b01;
                c.pc_write = 1'b1;
                c.retire   = 1'b1;
                pushStep(c, 1'($urandom), 1'($urandom), "exec_b");
            end
        endcase
    endtask

    task automatic runPlan();
        step_t s;
        while (plan.size() > 0) begin
            s = plan.pop_front();
            applyStimulus(s.rdy, s.az);
            @(negedge clk);
            checkOutput({"ctl_", s.tag}, 64'(observed()), 64'(s.exp));
            checkOutput("retire_cnt", 64'(retire_cnt), 64'(retired % (1 << RW)));
            checkOutput("illegal", 64'(illegal), 64'(s.ill));
            checkOutput("timeout_err", 64'(timeout_err), 64'(s.to));
            if (s.exp.retire) retired++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic runInstr(input int k, input int fw, input int mw, input logic az);
        op = pickOp(k);
        planInstr(k, fw, mw, az);
        runPlan();
    endtask

    task automatic assertReset(input string tag);
        reset_n = 1'b0;
        mem_if.mem_ready = 1'($urandom);
        #1;
        checkOutput({"reset_ctl_", tag}, 64'(observed()), 64'(0));
        checkOutput({"reset_cnt_", tag}, 64'(retire_cnt), 64'(0));
        checkOutput({"reset_flags_", tag}, 64'({illegal, timeout_err}), 64'(0));
    endtask

    // The cycle right after release is idle: outputs stay low, mem_ready ignored
    task automatic releaseReset();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        exp_ill = 1'b0;
        exp_to  = 1'b0;
        retired = 0;
        pushStep('0, 1'($urandom), 1'($urandom), "idle_after_reset");
        runPlan();
    endtask

    task automatic doReset(input string tag);
        @(posedge clk);
        #1;
        assertReset(tag);
        releaseReset();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int k;
        doReset("power_on");

        runInstr(K_R,   0, 0, 1'b0);
        runInstr(K_LD,  0, 3, 1'b0);
        runInstr(K_ST,  0, 0, 1'b0);
        runInstr(K_CBZ, 0, 0, 1'b0);
        runInstr(K_CBZ, 1, 0, 1'b1);
        runInstr(K_B,   2, 0, 1'b0);

        for (int i = 0; i < 24; i++) begin
            k = $urandom_range(0, 4);
            runInstr(k, $urandom_range(0, TIMEOUT - 1), $urandom_range(0, TIMEOUT - 1), 1'($urandom));
        end

        $display("[TB] illegal opcode 11'h7FF");
        op = 11'h7FF;
        planFetch(0);
        planDecode(K_R);
        exp_ill = 1'b1;
        planFault(4);
        runPlan();
        doReset("after_illegal");
        runInstr(K_R, 0, 0, 1'b0);

        $display("[TB] fetch timeout");
        op = pickOp(K_R);
        for (int i = 0; i < TIMEOUT; i++) pushStep(fetchCtl(1'b0), 1'b0, 1'($urandom), "fetch_wait");
        exp_to = 1'b1;
        planFault(3);
        runPlan();
        doReset("after_fetch_timeout");

        $display("[TB] data memory timeout");
        op = pickOp(K_LD);
        planFetch(0);
        planDecode(K_LD);
        pushStep('{alu_src: 1'b1, default: '0}, 1'b0, 1'b0, "exec_mem");
        for (int i = 0; i < TIMEOUT; i++) pushStep(memCtl(K_LD, 1'b0), 1'b0, 1'($urandom), "mem_wait");
        exp_to = 1'b1;
        planFault(3);
        runPlan();
        doReset("after_mem_timeout");

        $display("[TB] reset during store access");
        op = pickOp(K_ST);
        planFetch(0);
        planDecode(K_ST);
        pushStep('{alu_src: 1'b1, reg2loc: 1'b1, default: '0}, 1'b0, 1'b0, "exec_mem");
        runPlan();
        applyStimulus(1'b0, 1'b0);
        #2;
        checkOutput("store_in_flight", 64'(observed()), 64'(memCtl(K_ST, 1'b0)));
        assertReset("mid_store");
        releaseReset();
        runInstr(K_ST, 1, 2, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
